// File: rtl/lc3_mem_requester.sv
// LC-3 MAR/MDR memory initiator: sequences bus strobes for single load/store
// requests, waits on memory ready R, and returns data or a timeout error.
`timescale 1ns/1ps
module lc3_mem_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        GateMDR,
  output logic        MIO_EN,
  output logic        RW,
  input  logic        R,
  inout  wire  [15:0] main_bus
);

  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_WAIT = 3'd3,
    S_CAPT = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_timeout;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;

  logic                r_req_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;
  logic                r_ld_mar;
  logic                r_ld_mdr;
  logic                r_gate_mdr;
  logic                r_mio_en;
  logic                r_rw;
  logic                r_bus_oe;
  logic [DATA_W-1:0]   r_bus_out;

  // Next-state decode; a ready R takes priority over the timeout limit.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: if (req_valid) w_state_nxt = S_ADDR;
      S_ADDR: w_state_nxt = r_we ? S_DATA : S_WAIT;
      S_DATA: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (R) begin
          w_state_nxt = r_we ? S_RESP : S_CAPT;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = S_RESP;
          w_timeout   = 1'b1;
        end
      end
      S_CAPT:  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, request latch, wait counter and Moore outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_ld_mar     <= 1'b0;
      r_ld_mdr     <= 1'b0;
      r_gate_mdr   <= 1'b0;
      r_mio_en     <= 1'b0;
      r_rw         <= 1'b0;
      r_bus_oe     <= 1'b0;
      r_bus_out    <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_IDLE && req_valid) begin
        r_we    <= req_we;
        r_wdata <= req_wdata;
      end

      r_cnt <= (r_state == S_WAIT && w_state_nxt == S_WAIT) ? r_cnt + CNT_W'(1) : '0;

      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_ld_mar     <= (w_state_nxt == S_ADDR);
      r_ld_mdr     <= (w_state_nxt == S_DATA);
      r_mio_en     <= (w_state_nxt == S_WAIT);
      r_rw         <= (w_state_nxt == S_WAIT) && r_we;
      r_gate_mdr   <= (w_state_nxt == S_CAPT);
      r_resp_valid <= (w_state_nxt == S_RESP);
      r_resp_err   <= w_timeout;

      // ADDR is only entered from IDLE, so the address comes straight from the request.
      r_bus_oe <= (w_state_nxt == S_ADDR) || (w_state_nxt == S_DATA);
      if (w_state_nxt == S_ADDR) begin
        r_bus_out <= req_addr;
      end else if (w_state_nxt == S_DATA) begin
        r_bus_out <= r_wdata;
      end

      if (r_state == S_CAPT) begin
        r_resp_rdata <= main_bus;
      end else if (r_state == S_WAIT && w_state_nxt == S_RESP) begin
        r_resp_rdata <= '0;
      end
    end
  end

  assign main_bus   = r_bus_oe ? r_bus_out : {DATA_W{1'bz}};
  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign LD_MAR     = r_ld_mar;
  assign LD_MDR     = r_ld_mdr;
  assign GateMDR    = r_gate_mdr;
  assign MIO_EN     = r_mio_en;
  assign RW         = r_rw;

endmodule

// File: tb/tb_lc3_mem_requester.sv
// Bench for lc3_mem_requester: a behavioural LC-3 memory on main_bus, a fixed
// vector table, a reset-mid-store sequence and random traffic against a model.
`timescale 1ns/1ps
module tb_lc3_mem_requester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        LD_MAR, LD_MDR, GateMDR, MIO_EN, RW;
  logic        dev_r;
  wire  [15:0] main_bus;

  lc3_mem_requester #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .GateMDR(GateMDR), .MIO_EN(MIO_EN),
    .RW(RW), .R(dev_r), .main_bus(main_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural memory: R rises after dev_stall extra enabled cycles, never if dev_never.
  logic [15:0] dev_mem [0:65535];
  logic [15:0] dev_mar = '0;
  logic [15:0] dev_mdr = '0;
  int          dev_cnt = 0;
  int          dev_stall = 0;
  bit          dev_never = 1'b0;

  assign main_bus = GateMDR ? dev_mdr : 16'hzzzz;

  always @(posedge clk) begin
    if (LD_MAR) dev_mar <= main_bus;
    if (LD_MDR) dev_mdr <= main_bus;
    if (!MIO_EN) begin
      dev_r   <= 1'b0;
      dev_cnt <= 0;
    end else if (!dev_never && dev_cnt == dev_stall) begin
      dev_r <= 1'b1;
      if (RW) dev_mem[dev_mar] <= dev_mdr;
      else    dev_mdr <= dev_mem[dev_mar];
    end else begin
      dev_cnt <= dev_cnt + 1;
    end
  end

  // Protocol monitor.
  int   acc_cnt = 0;
  int   mio_cnt = 0;
  logic prev_resp = 1'b0, prev_mio = 1'b0, prev_rw = 1'b0;

  always @(posedge clk) if (req_valid && req_ready) acc_cnt++;

  always @(negedge clk) begin
    if (GateMDR) chk("bus_excl", {30'd0, LD_MAR, LD_MDR}, 32'd0);
    if (LD_MAR) chk("strobe_excl", 32'(LD_MDR), 32'd0);
    if (resp_valid) chk("resp_width", 32'(prev_resp), 32'd0);
    if (MIO_EN && prev_mio) chk("rw_const", 32'(RW), 32'(prev_rw));
    if (MIO_EN) mio_cnt++;
    prev_resp = resp_valid;
    prev_mio  = MIO_EN;
    prev_rw   = RW;
  end

  // Reference model memory, independent of the device array.
  logic [15:0] model_mem [0:65535];

  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int stall, input bit never, input bit hold,
                        output int lat, output logic [15:0] rd, output logic err,
                        output int mio, output int acc);
    int acc0, mio0;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    dev_stall = stall;
    dev_never = never;
    acc0 = acc_cnt;
    mio0 = mio_cnt;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    lat = -1;
    rd  = 16'hxxxx;
    err = 1'bx;
    @(posedge clk);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("mar_strobe", 32'(LD_MAR), 32'd1);
        chk("mar_bus", 32'(main_bus), 32'(addr));
      end
      if (c == 2 && we) begin
        chk("mdr_strobe", 32'(LD_MDR), 32'd1);
        chk("mdr_bus", 32'(main_bus), 32'(wdata));
      end
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        err = resp_err;
        break;
      end
      if (!hold) begin
        req_valid = 1'b0;
      end else begin
        req_we    = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
      end
    end
    req_valid = 1'b0;
    if (lat < 0) chk("resp_seen", 32'd0, 32'd1);
    mio = mio_cnt - mio0;
    acc = acc_cnt - acc0;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          stall;
    bit          never;
    int          lat;
    logic [15:0] rd;
    logic        err;
    int          mio;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int          lat, mio, acc, e_lat, e_mio;
    logic [15:0] rd, e_rd, a, w;
    logic        err, we;
    bit          nv;
    int          st;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      dev_mem[i]   = 16'(i) ^ 16'h5A5A;
      model_mem[i] = 16'(i) ^ 16'h5A5A;
    end
    dev_mem[16'h3000]   = 16'hBEEF;
    model_mem[16'h3000] = 16'hBEEF;

    //            we    addr      wdata     stall never lat rd        err   mio
    tbl[0] = '{1'b0, 16'h3000, 16'h0000, 0,  1'b0, 5,  16'hBEEF, 1'b0, 2};
    tbl[1] = '{1'b1, 16'h4001, 16'h1234, 0,  1'b0, 5,  16'h0000, 1'b0, 2};
    tbl[2] = '{1'b0, 16'h4001, 16'h0000, 0,  1'b0, 5,  16'h1234, 1'b0, 2};
    tbl[3] = '{1'b0, 16'h3000, 16'h0000, 0,  1'b1, 18, 16'h0000, 1'b1, 16};
    tbl[4] = '{1'b0, 16'h4001, 16'h0000, 0,  1'b0, 5,  16'h1234, 1'b0, 2};
    tbl[5] = '{1'b1, 16'h5000, 16'hCAFE, 0,  1'b1, 19, 16'h0000, 1'b1, 16};
    tbl[6] = '{1'b0, 16'h5000, 16'h0000, 5,  1'b0, 10, 16'h0A5A, 1'b0, 7};
    tbl[7] = '{1'b1, 16'h3001, 16'h00FF, 5,  1'b0, 10, 16'h0000, 1'b0, 7};
    tbl[8] = '{1'b0, 16'h3001, 16'h0000, 14, 1'b0, 19, 16'h00FF, 1'b0, 16};
    tbl[9] = '{1'b0, 16'h3000, 16'h0000, 15, 1'b0, 18, 16'h0000, 1'b1, 16};

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_strobes", {27'd0, LD_MAR, LD_MDR, GateMDR, MIO_EN, RW}, 32'd0);
    chk("rst_resp", {15'd0, resp_valid, resp_err, resp_rdata}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].stall, tbl[i].never,
             bit'(i % 2), lat, rd, err, mio, acc);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_mio", i), 32'(mio), 32'(tbl[i].mio));
      chk($sformatf("tbl%0d_accepts", i), 32'(acc), 32'd1);
      if (tbl[i].we && !tbl[i].never) model_mem[tbl[i].addr] = tbl[i].wdata;
    end
    chk("mem_4001", 32'(dev_mem[16'h4001]), 32'h1234);
    chk("mem_5000_untouched", 32'(dev_mem[16'h5000]), 32'h0A5A);

    // Reset pulsed while a store sits in WAIT: no response and no write may follow.
    @(negedge clk);
    dev_stall = 3; dev_never = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h4002; req_wdata = 16'h7777;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_wait", 32'(MIO_EN), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {27'd0, LD_MAR, LD_MDR, GateMDR, MIO_EN, RW}, 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_resp", {15'd0, resp_valid, resp_err, resp_rdata}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_resp", 32'(resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
    end
    do_req(1'b0, 16'h4002, 16'h0000, 0, 1'b0, 1'b0, lat, rd, err, mio, acc);
    chk("post_rst_lat", 32'(lat), 32'd5);
    chk("post_rst_rdata", 32'(rd), 32'h1A58);
    chk("post_rst_err", 32'(err), 32'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom);
      a  = 16'h4000 + 16'($urandom_range(0, 7));
      w  = 16'($urandom);
      nv = ($urandom_range(0, 7) == 0);
      st = $urandom_range(0, 14);
      e_lat = nv ? (18 + int'(we)) : (5 + st);
      e_mio = nv ? 16 : (st + 2);
      e_rd  = (nv || we) ? 16'h0000 : model_mem[a];
      do_req(we, a, w, st, nv, 1'($urandom), lat, rd, err, mio, acc);
      chk("rnd_lat", 32'(lat), 32'(e_lat));
      chk("rnd_rdata", 32'(rd), 32'(e_rd));
      chk("rnd_err", 32'(err), 32'(nv));
      chk("rnd_mio", 32'(mio), 32'(e_mio));
      chk("rnd_accepts", 32'(acc), 32'd1);
      if (we && !nv) model_mem[a] = w;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
